// File: rtl/gf180mcu_fd_sc_mcu9t5v0__evtdec4_pkg.sv
// Shared constants, FSM state type and capture-mode encodings for the 4-source event decoder.
package gf180mcu_fd_sc_mcu9t5v0__evtdec4_pkg;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned IDX_W   = 2;

  localparam int unsigned EDGE_LEVEL = 0;
  localparam int unsigned EDGE_RISE  = 1;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__evtdec4_if.sv
// VLD/IDX/ACK grant handshake between the event decoder (master) and its consumer (slave).
interface gf180mcu_fd_sc_mcu9t5v0__evtdec4_if;
  import gf180mcu_fd_sc_mcu9t5v0__evtdec4_pkg::*;

  logic             VLD;
  logic [IDX_W-1:0] IDX;
  logic             ACK;

  modport master (output VLD, output IDX, input ACK);
  modport slave  (input VLD, input IDX, output ACK);

endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rrpick4.sv
// Combinational round-robin picker: first set req bit scanning ptr, ptr+1, ... modulo 4.
module gf180mcu_fd_sc_mcu9t5v0__rrpick4
  import gf180mcu_fd_sc_mcu9t5v0__evtdec4_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    logic             found;
    any   = |req;
    idx   = '0;
    found = 1'b0;
    cand  = ptr;
    // Index arithmetic is IDX_W bits wide, so 3 + 1 wraps to 0 naturally.
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      cand = ptr + IDX_W'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__evtdec4.sv
// 4-source sticky event capture with OR-merged Z and round-robin VLD/IDX/ACK service.
// Optional overflow flags are built when GF180MCU_EVTDEC4_OVF_EN is defined.
module gf180mcu_fd_sc_mcu9t5v0__evtdec4
  import gf180mcu_fd_sc_mcu9t5v0__evtdec4_pkg::*;
#(
  parameter int unsigned EDGE_MODE   = EDGE_LEVEL,
  parameter int unsigned SYNC_STAGES = 0
) (
  input  logic CLK,
  input  logic RN,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic A4,
  gf180mcu_fd_sc_mcu9t5v0__evtdec4_if.master hs,
  output logic Z,
`ifdef GF180MCU_EVTDEC4_OVF_EN
  input  logic               OVF_CLR,
  output logic [NUM_SRC-1:0] OVF,
`endif
  inout  wire  VDD,
  inout  wire  VSS
);

  logic [NUM_SRC-1:0] a_raw, a_s, ev, clr, pend_q, pend_d;
  logic [IDX_W-1:0]   idx_q, idx_d, ptr_q, ptr_d, pick;
  logic               vld_q, vld_d, z_q, pick_any;
  state_t             state_q, state_d;
  logic               unused_pwr;

  assign unused_pwr = VDD ^ VSS;
  assign a_raw      = {A4, A3, A2, A1};

  if (SYNC_STAGES == 0) begin : g_nosync
    assign a_s = a_raw;
  end else begin : g_sync
    logic [NUM_SRC-1:0] sq [SYNC_STAGES];
    always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
        for (int unsigned i = 0; i < SYNC_STAGES; i++) sq[i] <= '0;
      end else begin
        sq[0] <= a_raw;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) sq[i] <= sq[i-1];
      end
    end
    assign a_s = sq[SYNC_STAGES-1];
  end

  if (EDGE_MODE == EDGE_RISE) begin : g_edge
    // History resets to 0, so an input already high at reset release is one edge.
    logic [NUM_SRC-1:0] a_prev;
    always_ff @(posedge CLK or negedge RN) begin
      if (!RN) a_prev <= '0;
      else     a_prev <= a_s;
    end
    assign ev = a_s & ~a_prev;
  end else begin : g_level
    assign ev = a_s;
  end

  gf180mcu_fd_sc_mcu9t5v0__rrpick4 u_pick (
    .req (pend_q),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick)
  );

  always_comb begin
    clr = '0;
    if (state_q == PRESENT && hs.ACK) clr[idx_q] = 1'b1;
  end

  // A new event in the clearing cycle re-arms the source.
  assign pend_d = (pend_q & ~clr) | ev;

  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = PRESENT;
          vld_d   = 1'b1;
          idx_d   = pick;
        end
      end
      PRESENT: begin
        if (hs.ACK) begin
          state_d = IDLE;
          vld_d   = 1'b0;
          ptr_d   = idx_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      vld_q   <= 1'b0;
      idx_q   <= '0;
      ptr_q   <= '0;
      pend_q  <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      z_q     <= |pend_d;
    end
  end

  assign Z      = z_q;
  assign hs.VLD = vld_q;
  assign hs.IDX = idx_q;

`ifdef GF180MCU_EVTDEC4_OVF_EN
  logic [NUM_SRC-1:0] ovf_q;
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) ovf_q <= '0;
    else     ovf_q <= (ovf_q & ~{NUM_SRC{OVF_CLR}}) | (ev & pend_q & ~clr);
  end
  assign OVF = ovf_q;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__evtdec4.sv
// Directed self-checking bench: level-mode instance dut0 and rising-edge instance dut1.
module tb_gf180mcu_fd_sc_mcu9t5v0__evtdec4;
  import gf180mcu_fd_sc_mcu9t5v0__evtdec4_pkg::*;

  logic       CLK = 1'b0;
  logic       RN;
  logic [3:0] a0, a1;
  logic       z0, z1;
  wire        vdd, vss;
  int unsigned checks = 0;
  int unsigned errors = 0;

  assign vdd = 1'b1;
  assign vss = 1'b0;

  gf180mcu_fd_sc_mcu9t5v0__evtdec4_if hs0 ();
  gf180mcu_fd_sc_mcu9t5v0__evtdec4_if hs1 ();

`ifdef GF180MCU_EVTDEC4_OVF_EN
  logic       ovf_clr0, ovf_clr1;
  logic [3:0] ovf0, ovf1;
`endif

  always #5 CLK = ~CLK;

  gf180mcu_fd_sc_mcu9t5v0__evtdec4 #(.EDGE_MODE(EDGE_LEVEL), .SYNC_STAGES(0)) dut0 (
    .CLK (CLK), .RN (RN),
    .A1 (a0[0]), .A2 (a0[1]), .A3 (a0[2]), .A4 (a0[3]),
    .hs (hs0),
    .Z (z0),
`ifdef GF180MCU_EVTDEC4_OVF_EN
    .OVF_CLR (ovf_clr0), .OVF (ovf0),
`endif
    .VDD (vdd), .VSS (vss)
  );

  gf180mcu_fd_sc_mcu9t5v0__evtdec4 #(.EDGE_MODE(EDGE_RISE), .SYNC_STAGES(0)) dut1 (
    .CLK (CLK), .RN (RN),
    .A1 (a1[0]), .A2 (a1[1]), .A3 (a1[2]), .A4 (a1[3]),
    .hs (hs1),
    .Z (z1),
`ifdef GF180MCU_EVTDEC4_OVF_EN
    .OVF_CLR (ovf_clr1), .OVF (ovf1),
`endif
    .VDD (vdd), .VSS (vss)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int unsigned grants;
    logic        prev;
    logic [1:0]  gidx;

    RN = 1'b0; a0 = '0; a1 = '0; hs0.ACK = 1'b0; hs1.ACK = 1'b0;
`ifdef GF180MCU_EVTDEC4_OVF_EN
    ovf_clr0 = 1'b0; ovf_clr1 = 1'b0;
`endif
    tick(); tick();
    chk("rst_vld", 32'(hs0.VLD), 0);
    chk("rst_idx", 32'(hs0.IDX), 0);
    chk("rst_z",   32'(z0), 0);
    chk("rst_vld1", 32'(hs1.VLD), 0);
`ifdef GF180MCU_EVTDEC4_OVF_EN
    chk("rst_ovf0", 32'(ovf0), 0);
    chk("rst_ovf1", 32'(ovf1), 0);
`endif
    RN = 1'b1;
    tick();
    chk("idle_vld", 32'(hs0.VLD), 0);

    // Single A3 pulse, ptr=0
    a0[2] = 1'b1;
    tick(); chk("se_z", 32'(z0), 1); chk("se_vld0", 32'(hs0.VLD), 0);
    a0[2] = 1'b0;
    tick(); chk("se_vld", 32'(hs0.VLD), 1); chk("se_idx", 32'(hs0.IDX), 2);
    tick(); chk("se_hold_vld", 32'(hs0.VLD), 1); chk("se_hold_idx", 32'(hs0.IDX), 2);
    hs0.ACK = 1'b1;
    tick(); chk("se_ack_vld", 32'(hs0.VLD), 0); chk("se_ack_z", 32'(z0), 0);
    // ACK while idle with nothing pending
    tick(); chk("idle_ack_vld", 32'(hs0.VLD), 0); chk("idle_ack_z", 32'(z0), 0);
    hs0.ACK = 1'b0;

    // Wrap: ptr=3, A1+A2 pending -> IDX 0 then 1
    a0 = 4'b0011;
    tick(); chk("wr_z", 32'(z0), 1);
    a0 = '0;
    tick(); chk("wr_vld", 32'(hs0.VLD), 1); chk("wr_idx", 32'(hs0.IDX), 0);
    hs0.ACK = 1'b1;
    tick(); chk("wr_bubble", 32'(hs0.VLD), 0); chk("wr_z_keep", 32'(z0), 1);
    tick(); chk("wr_vld2", 32'(hs0.VLD), 1); chk("wr_idx2", 32'(hs0.IDX), 1);
    tick(); chk("wr_end_vld", 32'(hs0.VLD), 0); chk("wr_end_z", 32'(z0), 0);
    hs0.ACK = 1'b0;

    // Set/clear collision on source 1 (ptr=2)
    a0[1] = 1'b1;
    tick();
    a0[1] = 1'b0;
    tick(); chk("col_vld", 32'(hs0.VLD), 1); chk("col_idx", 32'(hs0.IDX), 1);
    hs0.ACK = 1'b1; a0[1] = 1'b1;
    tick(); chk("col_ack_vld", 32'(hs0.VLD), 0); chk("col_z", 32'(z0), 1);
    hs0.ACK = 1'b0; a0[1] = 1'b0;
    tick(); chk("col_re_vld", 32'(hs0.VLD), 1); chk("col_re_idx", 32'(hs0.IDX), 1);
    tick(); chk("col_re_hold", 32'(hs0.VLD), 1);
    hs0.ACK = 1'b1;
    tick(); chk("col_end_vld", 32'(hs0.VLD), 0); chk("col_end_z", 32'(z0), 0);
    hs0.ACK = 1'b0;

    // Asynchronous reset while presenting IDX=2
    a0[2] = 1'b1;
    tick();
    a0[2] = 1'b0;
    tick(); chk("ar_vld", 32'(hs0.VLD), 1); chk("ar_idx", 32'(hs0.IDX), 2);
    RN = 1'b0;
    #1;
    chk("ar_vld0", 32'(hs0.VLD), 0); chk("ar_idx0", 32'(hs0.IDX), 0); chk("ar_z0", 32'(z0), 0);
    #1;
    RN = 1'b1;
    tick(); tick();
    chk("ar_lost_vld", 32'(hs0.VLD), 0); chk("ar_lost_z", 32'(z0), 0);

    // Round-robin with ACK held high, ptr=0
    hs0.ACK = 1'b1; a0 = 4'hF;
    tick(); chk("rr_z", 32'(z0), 1); chk("rr_vld0", 32'(hs0.VLD), 0);
    a0 = '0;
    for (int k = 0; k < 4; k++) begin
      tick(); chk("rr_vld", 32'(hs0.VLD), 1); chk("rr_idx", 32'(hs0.IDX), 32'(k));
      tick(); chk("rr_bubble", 32'(hs0.VLD), 0);
    end
    chk("rr_end_z", 32'(z0), 0);
    hs0.ACK = 1'b0;

    // Edge mode: A4 held high 20 cycles gives one grant
    grants = 0; prev = 1'b0; gidx = '0;
    a1[3] = 1'b1; hs1.ACK = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (hs1.VLD && !prev) begin grants++; gidx = hs1.IDX; end
      prev = hs1.VLD;
    end
    chk("edge_grants", grants, 1);
    chk("edge_idx", 32'(gidx), 3);

    // Edge mode: A4 still high across reset release counts once
    RN = 1'b0;
    tick(); tick();
    RN = 1'b1;
    grants = 0; prev = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (hs1.VLD && !prev) grants++;
      prev = hs1.VLD;
    end
    chk("edge_rst_grants", grants, 1);
    a1[3] = 1'b0; hs1.ACK = 1'b0;
    tick();

`ifdef GF180MCU_EVTDEC4_OVF_EN
    // Repeat A1 event while pending and unacked
    a0[0] = 1'b1;
    tick();
    a0[0] = 1'b0;
    tick(); chk("ovf_none", 32'(ovf0), 0); chk("ovf_vld", 32'(hs0.VLD), 1);
    a0[0] = 1'b1;
    tick(); chk("ovf_set", 32'(ovf0), 1);
    a0[0] = 1'b0;
    tick(); chk("ovf_sticky", 32'(ovf0), 1);
    ovf_clr0 = 1'b1;
    tick(); chk("ovf_clr", 32'(ovf0), 0);
    ovf_clr0 = 1'b0; hs0.ACK = 1'b1;
    tick(); chk("ovf_ack_vld", 32'(hs0.VLD), 0);
    hs0.ACK = 1'b0;
    chk("ovf1_quiet", 32'(ovf1), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
